// File: rtl/state_list_ctrl.sv
// state_list_ctrl: level bookkeeping, implication/analysis sequencing and
// backtrack level selection for one variable bin.
// Ports:
//   clk, rst         - clock, async active-low reset
//   apply_imply_i    - implication phase active
//   find_imply_i     - per-variable implied flags
//   find_conflict_i  - per-variable conflict flags
//   apply_analyze_i  - conflict analysis start pulse
//   apply_bkt_cur_bin_i - backtrack request for this bin
//   base_lvl_en/base_lvl_i - base level load
//   findindex_i      - level-search hit vector
//   max_lvl_i        - max level among bin variables
//   cur_local_lvl_i  - local decision level
//   cur_lvl_o        - base + local level
//   local_bkt_lvl_o  - index of highest findindex_i bit
//   bkt_lvl_o        - registered backtrack level
//   find_conflict_o  - any conflict flag set
//   done_imply_o, add_learntc_en_o, done_analyze_o,
//   done_bkt_cur_bin_o - registered status pulses
module state_list_ctrl #(
  parameter int NUM_VARS  = 8,
  parameter int WIDTH_LVL = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 apply_imply_i,
  input  logic [NUM_VARS-1:0]  find_imply_i,
  input  logic [NUM_VARS-1:0]  find_conflict_i,
  input  logic                 apply_analyze_i,
  input  logic                 apply_bkt_cur_bin_i,
  input  logic                 base_lvl_en,
  input  logic [WIDTH_LVL-1:0] base_lvl_i,
  input  logic [7:0]           findindex_i,
  input  logic [WIDTH_LVL-1:0] max_lvl_i,
  input  logic [WIDTH_LVL-1:0] cur_local_lvl_i,
  output logic [WIDTH_LVL-1:0] cur_lvl_o,
  output logic [WIDTH_LVL-1:0] local_bkt_lvl_o,
  output logic [WIDTH_LVL-1:0] bkt_lvl_o,
  output logic                 find_conflict_o,
  output logic                 done_imply_o,
  output logic                 add_learntc_en_o,
  output logic                 done_analyze_o,
  output logic                 done_bkt_cur_bin_o
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    FIND_LEARNTC = 2'd1,
    ADD_LEARNTC  = 2'd2,
    ANALYZE_DONE = 2'd3
  } state_t;

  state_t                r_state;
  logic [WIDTH_LVL-1:0]  r_base_lvl;
  logic [WIDTH_LVL-1:0]  r_bkt_lvl;
  logic [NUM_VARS-1:0]   r_imply_pre;
  logic [NUM_VARS-1:0]   r_conflict_pre;
  logic                  r_done_imply;
  logic                  r_add_learntc;
  logic                  r_done_analyze;
  logic                  r_done_bkt;
  logic [2:0]            w_enc;
  logic [WIDTH_LVL-1:0]  w_local_bkt;

  assign cur_lvl_o       = r_base_lvl + cur_local_lvl_i;
  assign find_conflict_o = |find_conflict_i;

  // Priority encoder: later iterations win, so the highest set bit sticks.
  always_comb begin
    w_enc = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (findindex_i[i]) w_enc = 3'(i);
    end
  end

  assign w_local_bkt     = {{(WIDTH_LVL-3){1'b0}}, w_enc};
  assign local_bkt_lvl_o = w_local_bkt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_base_lvl     <= '0;
      r_bkt_lvl      <= '0;
      r_imply_pre    <= '0;
      r_conflict_pre <= '0;
      r_done_imply   <= 1'b0;
      r_done_bkt     <= 1'b0;
    end else begin
      if (base_lvl_en) r_base_lvl <= base_lvl_i;
      r_imply_pre    <= find_imply_i;
      r_conflict_pre <= find_conflict_i;
      r_done_imply   <= apply_imply_i &&
                        (find_imply_i == r_imply_pre);
      // Empty hit vector means the target lies in another bin.
      if (findindex_i == 8'd0) r_bkt_lvl <= max_lvl_i;
      else                     r_bkt_lvl <= r_base_lvl + w_local_bkt;
      r_done_bkt     <= apply_bkt_cur_bin_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_add_learntc  <= 1'b0;
      r_done_analyze <= 1'b0;
    end else begin
      r_add_learntc  <= (r_state == ADD_LEARNTC);
      r_done_analyze <= (r_state == ANALYZE_DONE);
      case (r_state)
        IDLE:
          if (apply_analyze_i) r_state <= FIND_LEARNTC;
        FIND_LEARNTC:
          if (find_conflict_i != r_conflict_pre)
            r_state <= ADD_LEARNTC;
        ADD_LEARNTC:  r_state <= ANALYZE_DONE;
        ANALYZE_DONE: r_state <= IDLE;
        default:      r_state <= IDLE;
      endcase
    end
  end

  assign bkt_lvl_o          = r_bkt_lvl;
  assign done_imply_o       = r_done_imply;
  assign add_learntc_en_o   = r_add_learntc;
  assign done_analyze_o     = r_done_analyze;
  assign done_bkt_cur_bin_o = r_done_bkt;

endmodule

// File: tb/tb_state_list_ctrl.sv
// tb_state_list_ctrl: directed checks of state_list_ctrl.
// One task per feature, inline comparisons, single summary line.
module tb_state_list_ctrl;

  localparam int NV = 8;
  localparam int WL = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          apply_imply_i;
  logic [NV-1:0] find_imply_i;
  logic [NV-1:0] find_conflict_i;
  logic          apply_analyze_i;
  logic          apply_bkt_cur_bin_i;
  logic          base_lvl_en;
  logic [WL-1:0] base_lvl_i;
  logic [7:0]    findindex_i;
  logic [WL-1:0] max_lvl_i;
  logic [WL-1:0] cur_local_lvl_i;
  logic [WL-1:0] cur_lvl_o;
  logic [WL-1:0] local_bkt_lvl_o;
  logic [WL-1:0] bkt_lvl_o;
  logic          find_conflict_o;
  logic          done_imply_o;
  logic          add_learntc_en_o;
  logic          done_analyze_o;
  logic          done_bkt_cur_bin_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  state_list_ctrl #(.NUM_VARS(NV), .WIDTH_LVL(WL)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .apply_imply_i       (apply_imply_i),
    .find_imply_i        (find_imply_i),
    .find_conflict_i     (find_conflict_i),
    .apply_analyze_i     (apply_analyze_i),
    .apply_bkt_cur_bin_i (apply_bkt_cur_bin_i),
    .base_lvl_en         (base_lvl_en),
    .base_lvl_i          (base_lvl_i),
    .findindex_i         (findindex_i),
    .max_lvl_i           (max_lvl_i),
    .cur_local_lvl_i     (cur_local_lvl_i),
    .cur_lvl_o           (cur_lvl_o),
    .local_bkt_lvl_o     (local_bkt_lvl_o),
    .bkt_lvl_o           (bkt_lvl_o),
    .find_conflict_o     (find_conflict_o),
    .done_imply_o        (done_imply_o),
    .add_learntc_en_o    (add_learntc_en_o),
    .done_analyze_o      (done_analyze_o),
    .done_bkt_cur_bin_o  (done_bkt_cur_bin_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    apply_imply_i = 0; find_imply_i = '0;
    find_conflict_i = '0; apply_analyze_i = 0;
    apply_bkt_cur_bin_i = 0; base_lvl_en = 0;
    base_lvl_i = '0; findindex_i = '0;
    max_lvl_i = '0; cur_local_lvl_i = '0;
    #23;
    n_vec++;
    if ({bkt_lvl_o, cur_lvl_o, done_imply_o, add_learntc_en_o,
         done_analyze_o, done_bkt_cur_bin_o} !== '0) begin
      $display("FAIL reset: bkt=%0d cur=%0d flags=%b%b%b%b want 0",
               bkt_lvl_o, cur_lvl_o, done_imply_o,
               add_learntc_en_o, done_analyze_o, done_bkt_cur_bin_o);
      n_err++;
    end
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_levels();
    base_lvl_en = 1; base_lvl_i = 16'd5;
    step();
    base_lvl_en = 0; base_lvl_i = 16'd99;
    cur_local_lvl_i = 16'd3;
    #1;
    n_vec++;
    if (cur_lvl_o !== 16'd8) begin
      $display("FAIL cur_lvl: got %0d want 8", cur_lvl_o);
      n_err++;
    end
    step();
    n_vec++;
    if (cur_lvl_o !== 16'd8) begin
      $display("FAIL base_hold: got %0d want 8", cur_lvl_o);
      n_err++;
    end
    base_lvl_en = 1; base_lvl_i = 16'hFFFF;
    step();
    base_lvl_en = 0;
    cur_local_lvl_i = 16'd2;
    #1;
    n_vec++;
    if (cur_lvl_o !== 16'd1) begin
      $display("FAIL cur_lvl_wrap: got %0d want 1", cur_lvl_o);
      n_err++;
    end
    cur_local_lvl_i = '0;
  endtask

  task automatic test_imply();
    apply_imply_i = 1; find_imply_i = 8'h01;
    step();
    n_vec++;
    if (done_imply_o !== 1'b0) begin
      $display("FAIL imply_01: got %b want 0", done_imply_o);
      n_err++;
    end
    find_imply_i = 8'h03;
    step();
    n_vec++;
    if (done_imply_o !== 1'b0) begin
      $display("FAIL imply_03: got %b want 0", done_imply_o);
      n_err++;
    end
    step();
    n_vec++;
    if (done_imply_o !== 1'b1) begin
      $display("FAIL imply_stable: got %b want 1", done_imply_o);
      n_err++;
    end
    apply_imply_i = 0;
    step();
    n_vec++;
    if (done_imply_o !== 1'b0) begin
      $display("FAIL imply_off: got %b want 0", done_imply_o);
      n_err++;
    end
    find_imply_i = '0;
  endtask

  task automatic test_analyze();
    logic [3:0] exp_add;
    logic [3:0] exp_done;
    exp_add  = 4'b0010;
    exp_done = 4'b0100;
    apply_analyze_i = 1;
    step();
    apply_analyze_i = 0;
    step();
    find_conflict_i = 8'h04;
    #1;
    n_vec++;
    if (find_conflict_o !== 1'b1) begin
      $display("FAIL conflict_or: got %b want 1", find_conflict_o);
      n_err++;
    end
    for (int k = 0; k < 4; k++) begin
      step();
      n_vec++;
      if (add_learntc_en_o !== exp_add[k] ||
          done_analyze_o !== exp_done[k]) begin
        $display("FAIL analyze_c%0d: add=%b done=%b want %b %b",
                 k, add_learntc_en_o, done_analyze_o,
                 exp_add[k], exp_done[k]);
        n_err++;
      end
    end
    // Back at IDLE: a conflict change alone must not start analysis.
    find_conflict_i = 8'h00;
    for (int k = 0; k < 4; k++) begin
      step();
      n_vec++;
      if (add_learntc_en_o !== 1'b0 || done_analyze_o !== 1'b0) begin
        $display("FAIL analyze_idle%0d: add=%b done=%b want 0 0",
                 k, add_learntc_en_o, done_analyze_o);
        n_err++;
      end
    end
    #1;
    n_vec++;
    if (find_conflict_o !== 1'b0) begin
      $display("FAIL conflict_none: got %b want 0", find_conflict_o);
      n_err++;
    end
  endtask

  task automatic test_bkt_lvl();
    base_lvl_en = 1; base_lvl_i = 16'd10;
    step();
    base_lvl_en = 0;
    findindex_i = 8'b0010_0100;
    #1;
    n_vec++;
    if (local_bkt_lvl_o !== 16'd5) begin
      $display("FAIL local_bkt: got %0d want 5", local_bkt_lvl_o);
      n_err++;
    end
    step();
    n_vec++;
    if (bkt_lvl_o !== 16'd15) begin
      $display("FAIL bkt_local: got %0d want 15", bkt_lvl_o);
      n_err++;
    end
    findindex_i = 8'h80;
    step();
    n_vec++;
    if (bkt_lvl_o !== 16'd17) begin
      $display("FAIL bkt_bit7: got %0d want 17", bkt_lvl_o);
      n_err++;
    end
    findindex_i = 8'h00; max_lvl_i = 16'd7;
    #1;
    n_vec++;
    if (local_bkt_lvl_o !== 16'd0) begin
      $display("FAIL local_zero: got %0d want 0", local_bkt_lvl_o);
      n_err++;
    end
    step();
    n_vec++;
    if (bkt_lvl_o !== 16'd7) begin
      $display("FAIL bkt_inter: got %0d want 7", bkt_lvl_o);
      n_err++;
    end
    // Base load and local backtrack on the same edge: old base used.
    findindex_i = 8'h01;
    base_lvl_en = 1; base_lvl_i = 16'd20;
    step();
    base_lvl_en = 0;
    n_vec++;
    if (bkt_lvl_o !== 16'd10) begin
      $display("FAIL bkt_simul: got %0d want 10", bkt_lvl_o);
      n_err++;
    end
    step();
    n_vec++;
    if (bkt_lvl_o !== 16'd20) begin
      $display("FAIL bkt_newbase: got %0d want 20", bkt_lvl_o);
      n_err++;
    end
    findindex_i = '0; max_lvl_i = '0;
    step();
  endtask

  task automatic test_bkt_done();
    logic [3:0] drv;
    logic [3:0] exp;
    drv = 4'b0011;
    exp = 4'b0110;
    for (int k = 0; k < 4; k++) begin
      apply_bkt_cur_bin_i = drv[k];
      #1;
      n_vec++;
      if (done_bkt_cur_bin_o !== exp[k]) begin
        $display("FAIL bkt_done_c%0d: got %b want %b",
                 k, done_bkt_cur_bin_o, exp[k]);
        n_err++;
      end
      step();
    end
    apply_bkt_cur_bin_i = 0;
  endtask

  task automatic test_reset_mid_analysis();
    base_lvl_en = 1; base_lvl_i = 16'd4;
    findindex_i = 8'h02;
    apply_bkt_cur_bin_i = 1;
    apply_analyze_i = 1;
    step();
    base_lvl_en = 0; findindex_i = '0;
    max_lvl_i = 16'd9;
    apply_analyze_i = 0;
    step();
    #2;
    rst = 1'b0;
    #1;
    n_vec++;
    if ({bkt_lvl_o, cur_lvl_o, done_imply_o, add_learntc_en_o,
         done_analyze_o, done_bkt_cur_bin_o} !== '0) begin
      $display("FAIL reset_mid: bkt=%0d cur=%0d flags=%b%b%b%b want 0",
               bkt_lvl_o, cur_lvl_o, done_imply_o,
               add_learntc_en_o, done_analyze_o, done_bkt_cur_bin_o);
      n_err++;
    end
    apply_bkt_cur_bin_i = 0;
    max_lvl_i = '0;
    find_conflict_i = 8'h10;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      n_vec++;
      if (add_learntc_en_o !== 1'b0 || done_analyze_o !== 1'b0) begin
        $display("FAIL reset_nopulse%0d: add=%b done=%b want 0 0",
                 k, add_learntc_en_o, done_analyze_o);
        n_err++;
      end
    end
    find_conflict_i = '0;
  endtask

  initial begin
    test_reset();
    test_levels();
    test_imply();
    test_analyze();
    test_bkt_lvl();
    test_bkt_done();
    test_reset_mid_analysis();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: sim did not finish");
    $fatal(1);
  end

endmodule

// File: doc/state_list_ctrl.md
STATE_LIST_CTRL -- requirements
Module: state_list_ctrl

Interface
REQ-001 Parameters: NUM_VARS, default 8, number of variables per bin (the encoder width is fixed at 8).
REQ-002 Parameters: WIDTH_LVL, default 16, level width.
REQ-003 Ports: clk  in  1  single clock; all state updates on the rising edge.
REQ-004 Ports: rst  in  1  reset, asynchronous and active-low.
REQ-005 Ports: apply_imply_i  in  1  implication phase active.
REQ-006 Ports: find_imply_i  in  NUM_VARS  per-variable "implied" flags.
REQ-007 Ports: find_conflict_i  in  NUM_VARS  per-variable conflict flags.
REQ-008 Ports: apply_analyze_i  in  1  start conflict analysis (pulse).
REQ-009 Ports: apply_bkt_cur_bin_i  in  1  backtrack request for the current bin.
REQ-010 Ports: base_lvl_en  in  1  load enable for the base level.
REQ-011 Ports: base_lvl_i  in  WIDTH_LVL  new base level.
REQ-012 Ports: findindex_i  in  8  level-search hit vector.
REQ-013 Ports: max_lvl_i  in  WIDTH_LVL  maximum level among the bin's variables.
REQ-014 Ports: cur_local_lvl_i  in  WIDTH_LVL  local decision level.
REQ-015 Ports: cur_lvl_o  out  WIDTH_LVL  global current level.
REQ-016 Ports: local_bkt_lvl_o  out  WIDTH_LVL  encoded local backtrack level.
REQ-017 Ports: bkt_lvl_o  out  WIDTH_LVL  registered backtrack level.
REQ-018 Ports: find_conflict_o  out  1  any conflict present.
REQ-019 Ports: done_imply_o, add_learntc_en_o, done_analyze_o, done_bkt_cur_bin_o  out  1 each  registered status pulses.

Function
REQ-020 Base level: base_lvl_r SHALL load base_lvl_i on a clock edge where base_lvl_en=1, and otherwise hold its value.
REQ-021 Current level: cur_lvl_o SHALL equal base_lvl_r + cur_local_lvl_i, combinational, modulo 2^WIDTH_LVL.
REQ-022 Conflict flag: find_conflict_o SHALL equal the OR-reduction of find_conflict_i, combinational.
REQ-023 Implication history: find_imply_pre SHALL register find_imply_i on every edge.
REQ-024 Implication done: done_imply_o SHALL be registered to 1 when apply_imply_i=1 and find_imply_i==find_imply_pre, and to 0 otherwise.
REQ-025 Implication done latency: done_imply_o therefore asserts 1 cycle after the implication flags stop changing.
REQ-026 Analysis FSM: the FSM SHALL have 2-bit states IDLE=0, FIND_LEARNTC=1, ADD_LEARNTC=2, ANALYZE_DONE=3.
REQ-027 Analysis FSM transitions SHALL be:
- IDLE->FIND_LEARNTC when apply_analyze_i=1.
- FIND_LEARNTC->ADD_LEARNTC when find_conflict_i != find_conflict_pre; otherwise FIND_LEARNTC stays.
- ADD_LEARNTC->ANALYZE_DONE unconditionally.
- ANALYZE_DONE->IDLE unconditionally.
- Any illegal state->IDLE.
REQ-028 apply_analyze_i SHALL be ignored outside IDLE.
REQ-029 Conflict history: find_conflict_pre SHALL register find_conflict_i on every edge.
REQ-030 add_learntc_en_o SHALL be registered to 1 exactly for one cycle, the cycle after the state is ADD_LEARNTC.
REQ-031 done_analyze_o SHALL be registered to 1 exactly for one cycle, the cycle after the state is ANALYZE_DONE.
REQ-032 Encoder: local_bkt_lvl_o SHALL be the index (0..7) of the highest set bit of findindex_i, zero-extended to WIDTH_LVL; 0 when findindex_i=0.
REQ-033 Backtrack level: bkt_lvl_r SHALL update on every edge to max_lvl_i when findindex_i==0 (inter-bin backtrack), and otherwise to base_lvl_r + local_bkt_lvl_o, modulo 2^WIDTH_LVL.
REQ-034 bkt_lvl_o SHALL equal bkt_lvl_r.
REQ-035 done_bkt_cur_bin_o SHALL equal apply_bkt_cur_bin_i delayed by one cycle.
REQ-036 Simultaneous events: all paths SHALL be independent; e.g. base_lvl_en together with nonzero findindex_i uses the old base_lvl_r for bkt_lvl_r that edge.

Reset
REQ-037 While rst=0, all registers and registered outputs SHALL clear asynchronously: base_lvl_r, find_imply_pre, find_conflict_pre, FSM=IDLE, bkt_lvl_o, done_imply_o, add_learntc_en_o, done_analyze_o and done_bkt_cur_bin_o all go to 0.
REQ-038 Reset asserted mid-analysis SHALL abort to IDLE with no add_learntc_en_o or done_analyze_o pulse.

Verification
REQ-039 Base/current level: base_lvl_en=1 with base_lvl_i=5, then cur_local_lvl_i=3 -> cur_lvl_o=8; base_lvl_i=16'hFFFF with cur_local_lvl_i=2 -> cur_lvl_o=1.
REQ-040 Implication: apply_imply_i=1, find_imply_i steps 00->01->03->03 -> done_imply_o=0 until 1 cycle after the last change, then 1; apply_imply_i=0 -> done_imply_o=0.
REQ-041 Analysis: apply_analyze_i pulse, then find_conflict_i 00->04 two cycles later -> add_learntc_en_o 1-cycle pulse, done_analyze_o 1-cycle pulse on the next cycle, find_conflict_o=1, FSM back at IDLE.
REQ-042 Backtrack level: base_lvl_r=10 with findindex_i=8'b0010_0100 -> bkt_lvl_o=15 next cycle; findindex_i=0 with max_lvl_i=7 -> bkt_lvl_o=7.
REQ-043 Backtrack done: apply_bkt_cur_bin_i high for 2 cycles -> done_bkt_cur_bin_o high for the same 2 cycles, delayed by 1.
REQ-044 Reset: rst low while in FIND_LEARNTC -> all outputs 0 immediately, with no pulses after release.
